// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, frame FSM encoding, key-event record and the keypad digit decode.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] SC_KEY_0 = 8'h45;
    localparam logic [7:0] SC_KEY_1 = 8'h16;
    localparam logic [7:0] SC_KEY_2 = 8'h1E;
    localparam logic [7:0] SC_KEY_3 = 8'h26;
    localparam logic [7:0] SC_KEY_4 = 8'h25;
    localparam logic [7:0] SC_KEY_5 = 8'h2E;
    localparam logic [7:0] SC_KEY_6 = 8'h36;
    localparam logic [7:0] SC_KEY_7 = 8'h3D;
    localparam logic [7:0] SC_KEY_8 = 8'h3E;
    localparam logic [7:0] SC_KEY_9 = 8'h46;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam logic [3:0] DIGIT_NONE  = 4'hF;
    localparam logic [3:0] DIGIT_ENTER = 4'hB;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_event_t;

    // Enter decodes with or without the E0 prefix (main and keypad Enter).
    function automatic logic [3:0] ps2_digit(input logic [7:0] code, input logic ext);
        logic [3:0] d;
        d = DIGIT_NONE;
        if (code == SC_ENTER) begin
            d = DIGIT_ENTER;
        end else if (!ext) begin
            case (code)
                SC_KEY_0: d = 4'd0;
                SC_KEY_1: d = 4'd1;
                SC_KEY_2: d = 4'd2;
                SC_KEY_3: d = 4'd3;
                SC_KEY_4: d = 4'd4;
                SC_KEY_5: d = 4'd5;
                SC_KEY_6: d = 4'd6;
                SC_KEY_7: d = 4'd7;
                SC_KEY_8: d = 4'd8;
                SC_KEY_9: d = 4'd9;
                default:  d = DIGIT_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus tick-gated majority-free glitch filter: the output level only changes
// once FILTER_LEN consecutive tick samples agree.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_line,
    output logic o_level
);

    logic                  r_sync1;
    logic                  r_sync2;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= '1;
            r_level <= 1'b1;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_hist <= {r_hist[FILTER_LEN-2:0], r_sync2};
            end
            // Mixed history holds the previous level (hysteresis).
            if (&r_hist) begin
                r_level <= 1'b1;
            end else if (~|r_hist) begin
                r_level <= 1'b0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: filtered line sampling, 11-bit frame checking, E0/F0 prefix folding
// and a show-ahead key-event FIFO with a keypad digit decode of its head.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned FILTER_LEN    = 8,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned TIMEOUT_TICKS = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_ps2_clk,
    input  logic                          i_ps2_data,
    output logic                          o_evt_valid,
    input  logic                          i_evt_ready,
    output logic [7:0]                    o_evt_code,
    output logic                          o_evt_break,
    output logic                          o_evt_ext,
    output logic [3:0]                    o_evt_digit,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_frame_err,
    output logic                          o_overflow
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_div == DIV_W'(CLK_DIV - 1)) begin
            r_div  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_div  <= r_div + 1'b1;
            r_tick <= 1'b0;
        end
    end

    logic w_fclk;
    logic w_fdata;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_tick  (r_tick),
        .i_line  (i_ps2_clk),
        .o_level (w_fclk)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_tick  (r_tick),
        .i_line  (i_ps2_data),
        .o_level (w_fdata)
    );

    logic r_fclk_d;
    logic w_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fclk_d <= 1'b1;
        end else begin
            r_fclk_d <= w_fclk;
        end
    end

    assign w_fall = r_fclk_d & ~w_fclk;

    ps2_state_e       r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_sreg;
    logic             r_parity;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_byte_valid;
    logic [7:0]       r_byte;
    logic             r_frame_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_bit_cnt    <= '0;
            r_sreg       <= '0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    StIdle: begin
                        if (!w_fdata) begin
                            r_state   <= StData;
                            r_bit_cnt <= '0;
                        end
                    end
                    StData: begin
                        r_sreg    <= {w_fdata, r_sreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= StParity;
                        end
                    end
                    StParity: begin
                        r_parity <= w_fdata;
                        r_state  <= StStop;
                    end
                    StStop: begin
                        if (w_fdata && (^{r_sreg, r_parity})) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_sreg;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end else if (r_state != StIdle) begin
                if (r_tick) begin
                    if (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                        r_frame_err <= 1'b1;
                        r_state     <= StIdle;
                        r_to_cnt    <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    logic       r_ext;
    logic       r_brk;
    logic       w_is_ext;
    logic       w_is_brk;
    logic       w_push;
    ps2_event_t w_new_evt;

    assign w_is_ext  = (r_byte == PS2_PREFIX_EXT);
    assign w_is_brk  = (r_byte == PS2_PREFIX_BRK);
    assign w_push    = r_byte_valid && !w_is_ext && !w_is_brk;
    assign w_new_evt = '{code: r_byte, brk: r_brk, ext: r_ext};

    always_ff @(posedge i_clk) begin
        if (i_rst || r_frame_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_valid) begin
            if (w_is_ext) begin
                r_ext <= 1'b1;
            end else if (w_is_brk) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    ps2_event_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_wr;
    ps2_event_t       w_head;

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_evt_ready && !w_empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_new_evt;
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign o_evt_valid  = !w_empty;
    assign o_evt_code   = w_empty ? 8'h00 : w_head.code;
    assign o_evt_break  = w_empty ? 1'b0 : w_head.brk;
    assign o_evt_ext    = w_empty ? 1'b0 : w_head.ext;
    assign o_evt_digit  = w_empty ? DIGIT_NONE : ps2_digit(w_head.code, w_head.ext);
    assign o_fifo_count = r_count;
    assign o_frame_err  = r_frame_err;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: frames are bit-banged on the PS/2 lines, a reference
// model queues the expected events and a negedge monitor checks every FIFO handshake.
module tb_ps2_key_receiver;
    import ps2_pkg::*;

    localparam int unsigned CLK_DIV       = 4;
    localparam int unsigned FILTER_LEN    = 8;
    localparam int unsigned FIFO_DEPTH    = 2;
    localparam int unsigned TIMEOUT_TICKS = 256;
    localparam int          HALF          = 200;
    localparam int          CNT_W         = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ps2_clk = 1'b1;
    logic             ps2_data = 1'b1;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic [7:0]       evt_code;
    logic             evt_break;
    logic             evt_ext;
    logic [3:0]       evt_digit;
    logic [CNT_W-1:0] fifo_count;
    logic             frame_err;
    logic             overflow;

    ps2_key_receiver #(
        .CLK_DIV       (CLK_DIV),
        .FILTER_LEN    (FILTER_LEN),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_evt_valid  (evt_valid),
        .i_evt_ready  (evt_ready),
        .o_evt_code   (evt_code),
        .o_evt_break  (evt_break),
        .o_evt_ext    (evt_ext),
        .o_evt_digit  (evt_digit),
        .o_fifo_count (fifo_count),
        .o_frame_err  (frame_err),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } exp_evt_t;

    exp_evt_t   exp_q[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       exp_ovf = 1'b0;
    int         exp_err = 0;
    int         err_pulses = 0;
    int         errors = 0;
    int         checks = 0;
    int unsigned last_fall = 0;
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                     8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    function automatic logic [3:0] model_digit(input logic [7:0] c, input logic e);
        if (c == 8'h5A) return 4'hB;
        if (e) return 4'hF;
        for (int i = 0; i < 10; i++) begin
            if (digit_codes[i] == c) return 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference rules for an accepted (or rejected) byte; coincide marks a pop in the push cycle.
    task automatic model_byte(input logic [7:0] b, input bit bad, input bit coincide);
        if (bad) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < int'(FIFO_DEPTH) || coincide) begin
                exp_q.push_back('{code: b, brk: m_brk, ext: m_ext});
            end else begin
                exp_ovf = 1'b1;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input bit coincide);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_clk(HALF);
            if (i == 10) model_byte(b, bad_par, coincide);
            ps2_clk = 1'b0;
            last_fall = cyc;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_clk(HALF);
    endtask

    always @(negedge clk) begin : monitor
        exp_evt_t e;
        if (!rst && frame_err) err_pulses++;
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got code %0h expected no event", evt_code);
            end else begin
                e = exp_q.pop_front();
                check("evt_code", 32'(evt_code), 32'(e.code));
                check("evt_break", 32'(evt_break), 32'(e.brk));
                check("evt_ext", 32'(evt_ext), 32'(e.ext));
                check("evt_digit", 32'(evt_digit), 32'(model_digit(e.code, e.ext)));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] seq2 [7];
        logic [7:0] cs [5];
        int         start_err;
        int unsigned elapsed;
        int         n;

        seq2 = '{8'hF0, 8'h45, 8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A};
        wait_clk(5);
        rst = 1'b0;
        wait_clk(50);

        check("rst_valid", 32'(evt_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_code", 32'(evt_code), 0);
        check("rst_break", 32'(evt_break), 0);
        check("rst_ext", 32'(evt_ext), 0);
        check("rst_digit", 32'(evt_digit), 32'hF);

        // Single key, held in the FIFO until released.
        send_frame(8'h16, 1'b0, 11, 1'b0);
        check("t1_count", 32'(fifo_count), 1);
        check("t1_valid", 32'(evt_valid), 1);
        check("t1_head_code", 32'(evt_code), 32'h16);
        check("t1_head_digit", 32'(evt_digit), 1);
        evt_ready = 1'b1;
        wait_clk(3);
        check("t1_count_popped", 32'(fifo_count), 0);
        check("t1_pending", 32'(exp_q.size()), 0);

        // Prefix folding.
        for (int i = 0; i < 7; i++) send_frame(seq2[i], 1'b0, 11, 1'b0);
        wait_clk(10);
        check("t2_pending", 32'(exp_q.size()), 0);
        check("t2_frame_err", 32'(err_pulses), 32'(exp_err));

        // Parity error then a clean byte.
        send_frame(8'h1E, 1'b1, 11, 1'b0);
        send_frame(8'h26, 1'b0, 11, 1'b0);
        wait_clk(10);
        check("t3_frame_err", 32'(err_pulses), 32'(exp_err));
        check("t3_pending", 32'(exp_q.size()), 0);

        // Abandoned frame: start plus five data bits.
        start_err = err_pulses;
        send_frame(8'hA5, 1'b0, 6, 1'b0);
        n = 0;
        while (err_pulses == start_err && n < int'(TIMEOUT_TICKS * CLK_DIV) + 2000) begin
            wait_clk(1);
            n++;
        end
        elapsed = cyc - last_fall;
        exp_err++;
        check("t4_timeout_err", 32'(err_pulses), 32'(exp_err));
        check("t4_timeout_window",
              32'(elapsed >= TIMEOUT_TICKS * CLK_DIV && elapsed <= TIMEOUT_TICKS * CLK_DIV + 200),
              1);
        check("t4_state_idle", 32'(dut.r_state), 32'(StIdle));
        send_frame(8'h3D, 1'b0, 11, 1'b0);
        wait_clk(10);
        check("t4_pending", 32'(exp_q.size()), 0);

        // Overflow with random digit keys, then a push coinciding with a pop while full.
        evt_ready = 1'b0;
        wait_clk(2);
        check("t5_overflow_clear", 32'(overflow), 0);
        for (int k = 0; k < 5; k++) cs[k] = digit_codes[$urandom_range(0, 9)];
        for (int k = 0; k < int'(FIFO_DEPTH) + 2; k++) send_frame(cs[k], 1'b0, 11, 1'b0);
        check("t5_count_full", 32'(fifo_count), FIFO_DEPTH);
        check("t5_overflow", 32'(overflow), 32'(exp_ovf));
        check("t5_head_code", 32'(evt_code), 32'(cs[0]));
        fork
            send_frame(cs[4], 1'b0, 11, 1'b1);
            begin : pop_on_push
                int m;
                m = 0;
                while (!dut.w_push && m < 20000) begin
                    wait_clk(1);
                    m++;
                end
                if (dut.w_push) begin
                    evt_ready = 1'b1;
                    wait_clk(1);
                    evt_ready = 1'b0;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL t5_push_wait: got no push expected push within bound");
                end
            end
        join
        check("t5_count_after_swap", 32'(fifo_count), FIFO_DEPTH);
        check("t5_overflow_sticky", 32'(overflow), 1);
        evt_ready = 1'b1;
        wait_clk(1);
        evt_ready = 1'b0;
        wait_clk(1);
        check("t5_count_one", 32'(fifo_count), FIFO_DEPTH - 1);
        check("t5_pending_one", 32'(exp_q.size()), 1);

        // Reset in the middle of a frame with one event still queued.
        send_frame(8'(32'h80 | $urandom_range(0, 127)), 1'b0, 4, 1'b0);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_ovf = 1'b0;
        wait_clk(1);
        check("t6_valid", 32'(evt_valid), 0);
        check("t6_count", 32'(fifo_count), 0);
        check("t6_overflow", 32'(overflow), 0);
        check("t6_frame_err", 32'(frame_err), 0);
        check("t6_code", 32'(evt_code), 0);
        check("t6_digit", 32'(evt_digit), 32'hF);
        check("t6_state_idle", 32'(dut.r_state), 32'(StIdle));
        evt_ready = 1'b1;
        wait_clk(500);
        check("t6_no_event", 32'(evt_valid), 0);
        check("t6_no_err", 32'(err_pulses), 32'(exp_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
